// File: rtl/fp_result_commit.sv
// ----------------------------------------------------------------------------
// fp_result_commit
//   Commit stage behind the FP arithmetic units. Results arrive through a
//   valid/ready handshake. They are held in a 2-entry in-order FIFO and are
//   written to the FP register file through a shared write port. A
//   higher-priority writer can take that port for a cycle by raising rf_busy.
//   The block also keeps sticky overflow/underflow/invalid flags. These flags
//   are updated only when a result commits.
//
// Ports
//   clk, rst_n            : clock; asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready is pending < 2)
//   in_result             : IEEE-754 single-precision result
//   in_overflow           : overflow flag from the FP unit
//   in_underflow          : underflow flag from the FP unit
//   in_dest               : destination FP register index
//   rf_busy               : write port taken by a higher-priority writer
//   rf_we/rf_waddr/rf_wdata : RF write port (combinational from FIFO head)
//   flag_clr              : software clear of the sticky flags
//   sticky_ovf/unf/inv    : sticky exception flags
//   pending               : number of buffered entries (0..2)
//   busy                  : pending != 0
// ----------------------------------------------------------------------------
module fp_result_commit #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_overflow,
    input  logic        in_underflow,
    input  logic [4:0]  in_dest,
    input  logic        rf_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        flag_clr,
    output logic        sticky_ovf,
    output logic        sticky_unf,
    output logic        sticky_inv,
    output logic [1:0]  pending,
    output logic        busy
);

    // A NaN has an all-ones exponent. Take that exponent field from the
    // canonical NaN the units emit.
    localparam logic [7:0] EXP_MAX = QNAN[30:23];
    localparam logic [1:0] FULL    = 2'(DEPTH);

    logic [31:0] r_res  [DEPTH];
    logic        r_ovf  [DEPTH];
    logic        r_unf  [DEPTH];
    logic [4:0]  r_dest [DEPTH];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_pending;
    logic        r_sticky_ovf;
    logic        r_sticky_unf;
    logic        r_sticky_inv;

    logic        w_accept;
    logic        w_commit;
    logic        w_invalid;
    logic [31:0] w_head_res;

    // in_ready depends only on the registered count. This keeps rf_busy from
    // reaching the upstream handshake combinationally.
    assign in_ready   = (r_pending != FULL);
    assign w_accept   = in_valid && in_ready;
    // There is no bypass. An empty FIFO never commits, even if a result is
    // arriving in the same cycle.
    assign w_commit   = (r_pending != 2'd0) && !rf_busy;
    assign w_head_res = r_res[r_rptr];
    assign w_invalid  = (w_head_res[30:23] == EXP_MAX) && (w_head_res[22:0] != 23'd0);

    // The write port is driven to zero when idle. This avoids showing stale
    // head data on the shared bus.
    assign rf_we      = w_commit;
    assign rf_waddr   = w_commit ? r_dest[r_rptr] : 5'd0;
    assign rf_wdata   = w_commit ? w_head_res     : 32'd0;

    assign pending    = r_pending;
    assign busy       = (r_pending != 2'd0);
    assign sticky_ovf = r_sticky_ovf;
    assign sticky_unf = r_sticky_unf;
    assign sticky_inv = r_sticky_inv;

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i]  <= 32'd0;
                r_ovf[i]  <= 1'b0;
                r_unf[i]  <= 1'b0;
                r_dest[i] <= 5'd0;
            end
        end else if (w_accept) begin
            r_res[r_wptr]  <= in_result;
            r_ovf[r_wptr]  <= in_overflow;
            r_unf[r_wptr]  <= in_underflow;
            r_dest[r_wptr] <= in_dest;
        end
    end

    // Pointers and occupancy. The 1-bit pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_pending <= 2'd0;
        end else begin
            if (w_accept) r_wptr <= ~r_wptr;
            if (w_commit) r_rptr <= ~r_rptr;
            case ({w_accept, w_commit})
                2'b10:   r_pending <= r_pending + 2'd1;
                2'b01:   r_pending <= r_pending - 2'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Sticky flags. A set from a committing entry wins over a clear in the
    // same cycle. Flags that the commit does not set follow the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
            r_sticky_inv <= 1'b0;
        end else begin
            r_sticky_ovf <= (r_sticky_ovf & ~flag_clr) | (w_commit & r_ovf[r_rptr]);
            r_sticky_unf <= (r_sticky_unf & ~flag_clr) | (w_commit & r_unf[r_rptr]);
            r_sticky_inv <= (r_sticky_inv & ~flag_clr) | (w_commit & w_invalid);
        end
    end

endmodule

// File: tb/tb_fp_result_commit.sv
module tb_fp_result_commit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic [4:0]  in_dest;
    logic        rf_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flag_clr;
    logic        sticky_ovf;
    logic        sticky_unf;
    logic        sticky_inv;
    logic [1:0]  pending;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_result_commit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_underflow(in_underflow), .in_dest(in_dest),
        .rf_busy(rf_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_clr(flag_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
        .sticky_inv(sticky_inv), .pending(pending), .busy(busy)
    );

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic [4:0]  dest;
        logic        rbusy;
        logic        clr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  pend;
        logic        rdy;
        logic [2:0]  flg;   // {ovf, unf, inv}
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic        u;
        logic [4:0]  d;
    } ent_t;

    vec_t tbl [20];
    ent_t q[$];
    logic m_ovf, m_unf, m_inv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic u,
                         input logic [4:0] d, input logic b, input logic c);
        in_valid = v; in_result = r; in_overflow = o; in_underflow = u;
        in_dest = d; rf_busy = b; flag_clr = c;
    endtask

    function automatic logic is_nan(input logic [31:0] r);
        return (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
    endfunction

    initial begin
        // Single result, then drain
        tbl[0]  = '{1'b1, 32'h3FC0_0000, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b000};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h3FC0_0000, 2'd1, 1'b1, 3'b000};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b000};
        // A, B, C while busy; C held while full, then drained in order
        tbl[3]  = '{1'b1, 32'h4000_0000, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b000};
        tbl[4]  = '{1'b1, 32'h4040_0000, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,          2'd1, 1'b1, 3'b000};
        tbl[5]  = '{1'b1, 32'h4080_0000, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,          2'd2, 1'b0, 3'b000};
        tbl[6]  = '{1'b1, 32'h4080_0000, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 5'd1, 32'h4000_0000, 2'd2, 1'b0, 3'b000};
        tbl[7]  = '{1'b1, 32'h4080_0000, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 5'd2, 32'h4040_0000, 2'd1, 1'b1, 3'b000};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h4080_0000, 2'd1, 1'b1, 3'b000};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b000};
        // ovf entry then canonical qNaN
        tbl[10] = '{1'b1, 32'h3F80_0000, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b000};
        tbl[11] = '{1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1, 5'd5, 32'h3F80_0000, 2'd1, 1'b1, 3'b000};
        tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h7FC0_0000, 2'd1, 1'b1, 3'b100};
        tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b101};
        // clear with a simultaneous unf commit
        tbl[14] = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b101};
        tbl[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0001, 2'd1, 1'b1, 3'b101};
        tbl[16] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b010};
        // infinity is not invalid
        tbl[17] = '{1'b1, 32'h7F80_0000, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b010};
        tbl[18] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h7F80_0000, 2'd1, 1'b1, 3'b010};
        tbl[19] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          2'd0, 1'b1, 3'b010};

        // reset state
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata,      32'd0);
        chk("rst_pending",  32'(pending),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_flags",    32'({sticky_ovf, sticky_unf, sticky_inv}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven directed vectors
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].res, tbl[i].ovf, tbl[i].unf, tbl[i].dest, tbl[i].rbusy, tbl[i].clr);
            #1;
            chk($sformatf("v%0d_rf_we", i),    32'(rf_we),    32'(tbl[i].we));
            chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].wa));
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata,      tbl[i].wd);
            chk($sformatf("v%0d_pending", i),  32'(pending),  32'(tbl[i].pend));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_busy", i),     32'(busy),     32'(tbl[i].pend != 2'd0));
            chk($sformatf("v%0d_flags", i),    32'({sticky_ovf, sticky_unf, sticky_inv}), 32'(tbl[i].flg));
            @(posedge clk);
        end

        // reset mid-operation: two entries buffered, then the port frees up
        // and reset hits between edges
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h4100_0000 + 32'(i), 1'b1, 1'b0, 5'(9 + i), 1'b1, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("mid_pre_rf_we",   32'(rf_we),    32'd1);
        chk("mid_pre_pending", 32'(pending),  32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_pending",  32'(pending),  32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_rf_we",    32'(rf_we),    32'd0);
        chk("mid_rst_rf_wdata", rf_wdata,      32'd0);
        chk("mid_rst_flags",    32'({sticky_ovf, sticky_unf, sticky_inv}), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mid_after%0d_rf_we", i), 32'(rf_we), 32'd0);
            @(posedge clk);
        end

        // randomized run against a queue-based reference model
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_inv = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic e_we, e_rdy, hold;
            ent_t h;
            @(negedge clk);
            // a source that was refused must keep offering the same result
            hold = in_valid && (q.size() >= 2);
            if (!hold) begin
                logic [31:0] r;
                int sel;
                sel = $urandom_range(0, 9);
                r = $urandom;
                if (sel == 0) r = 32'h7FC0_0000;
                else if (sel == 1) r = {r[31], 8'hFF, 23'd0};
                else if (sel == 2) r = {r[31], 8'hFF, r[22:0] | 23'd1};
                drive(($urandom_range(0, 9) < 6), r, ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 7) == 0), 5'($urandom), 1'b0, 1'b0);
            end
            rf_busy  = ($urandom_range(0, 9) < 4);
            flag_clr = ($urandom_range(0, 19) == 0);
            #1;
            e_rdy = (q.size() < 2);
            e_we  = (q.size() > 0) && !rf_busy;
            h = '{32'h0, 1'b0, 1'b0, 5'd0};
            if (e_we) h = q[0];
            chk("rnd_rf_we",    32'(rf_we),    32'(e_we));
            chk("rnd_rf_waddr", 32'(rf_waddr), 32'(h.d));
            chk("rnd_rf_wdata", rf_wdata,      h.r);
            chk("rnd_pending",  32'(pending),  32'(q.size()));
            chk("rnd_in_ready", 32'(in_ready), 32'(e_rdy));
            chk("rnd_busy",     32'(busy),     32'(q.size() != 0));
            chk("rnd_flags",    32'({sticky_ovf, sticky_unf, sticky_inv}), 32'({m_ovf, m_unf, m_inv}));
            @(posedge clk);
            // model update for this edge
            m_ovf = (m_ovf & ~flag_clr) | (e_we & h.o);
            m_unf = (m_unf & ~flag_clr) | (e_we & h.u);
            m_inv = (m_inv & ~flag_clr) | (e_we & is_nan(h.r));
            if (e_we) void'(q.pop_front());
            if (in_valid && e_rdy) q.push_back('{in_result, in_overflow, in_underflow, in_dest});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_commit.md
# fp_result_commit

Downstream commit stage for the floating-point divider and other FP arithmetic units. It accepts a 32-bit result plus overflow/underflow flags from the combinational FP unit through a valid/ready handshake. It buffers up to two results and writes them in order to the FP register file through a shared write port that the integer-to-FP move path can pre-empt. It also keeps sticky exception flags for software.

## Interface
Parameters:
- `DEPTH`, 2, number of buffer entries; only 2 is supported.
- `QNAN`, 32'h7FC0_0000, canonical quiet NaN the FP units emit for invalid operations.

Ports:
- `clk` input 1: the only clock; everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: FP unit presents a result this cycle.
- `in_ready` output 1: buffer can accept; high when fewer than 2 entries are held.
- `in_result` input 32: IEEE-754 single result.
- `in_overflow` input 1: overflow flag from the unit.
- `in_underflow` input 1: underflow flag from the unit.
- `in_dest` input 5: destination FP register index.
- `rf_busy` input 1: the write port is taken by a higher-priority writer this cycle.
- `rf_we` output 1: register-file write enable.
- `rf_waddr` output 5: register-file write address.
- `rf_wdata` output 32: register-file write data.
- `flag_clr` input 1: software clear of the sticky flags.
- `sticky_ovf` output 1: sticky overflow flag.
- `sticky_unf` output 1: sticky underflow flag.
- `sticky_inv` output 1: sticky invalid flag.
- `pending` output 2: number of entries held, 0..2.
- `busy` output 1: equals `pending != 0`; the issue logic uses it to stall FP reads.

## Operation
- Storage is a 2-entry in-order FIFO. Each entry holds {result, ovf, unf, dest}.
- Write pointer and read pointer are each 1 bit. `pending` is a 2-bit counter.
- Accept: an entry is accepted when `in_valid && in_ready`. It is written at the write pointer, and the write pointer toggles.
- Commit: a commit happens when `pending != 0 && !rf_busy`.
  - `rf_we` is driven high with the head entry's dest and result.
  - The read pointer toggles.
- `rf_we`, `rf_waddr` and `rf_wdata` are combinational from the head entry.
  - When `rf_we` is 0, `rf_waddr` and `rf_wdata` are 0.
- Invalid detection at commit: an entry is invalid when result[30:23] == 8'hFF and result[22:0] != 0.
- Sticky flags are updated only on commit, never on accept.
  - `sticky_ovf |= head.ovf`.
  - `sticky_unf |= head.unf`.
  - `sticky_inv |= invalid`.
- When `flag_clr` and a commit that sets a flag occur in the same cycle, that flag ends at 1 (set wins). Flags the commit does not set are cleared.
- Simultaneous accept and commit: `pending` is unchanged, and both pointers toggle.
- Accept with `pending == 1` and a commit in the same cycle is legal.
- `in_ready` depends only on registered `pending`, never on `rf_busy`, so there is no combinational path from `rf_busy` to `in_ready`.
- Full (`pending == 2`): `in_ready` = 0. An asserted `in_valid` is ignored and must be held by the source.
- Empty (`pending == 0`): no commit occurs. There is no bypass, so an input is never written to the RF in its own arrival cycle.
- Pointer wrap: pointers are 1 bit and wrap naturally. Order is preserved across the wrap.

## Timing
- Reset (`rst_n` low, asynchronous) clears:
  - pointers and `pending` to 0;
  - all three sticky flags to 0;
  - all FIFO entries to 0.
- Resulting output values under reset:
  - `in_ready` = 1;
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0;
  - `busy` = 0.
- Reset asserted mid-operation discards every buffered entry. No partial write occurs, because `rf_we` falls to 0 combinationally with reset.
- Latency: a result accepted at edge N is written at edge N+1 at the earliest. That is, `rf_we` is high during the cycle after acceptance.
- Each cycle `rf_busy` is held adds one cycle of latency.
- Throughput: one commit per cycle when `rf_busy` = 0.
- A sticky flag is visible the cycle after its commit edge.

## Test plan
- Single result, then drain:
  - Stimulus: 32'h3FC0_0000 to dest 3, flags 0.
  - Response: `in_ready` = 1 throughout; next cycle `rf_we` = 1, `rf_waddr` = 3, `rf_wdata` = 32'h3FC0_0000; `pending` returns to 0; all sticky flags remain 0.
- Back-to-back with `rf_busy`:
  - Stimulus: results A (dest 1), B (dest 2) and C (dest 4) offered on consecutive cycles while `rf_busy` = 1.
  - Response: A and B are accepted; `pending` = 2 and `in_ready` = 0, so C is held.
  - After release, the RF sees A, then B, then C, one per cycle, in order across the pointer wrap.
- Flags:
  - Stimulus: commit an entry with ovf = 1, then commit 32'h7FC0_0000 with flags 0.
  - Response: `sticky_ovf` = 1 after the first commit, `sticky_inv` = 1 after the second, and `sticky_unf` = 0.
- Clear vs set:
  - Stimulus: `flag_clr` = 1 in the same cycle as a commit with unf = 1, while `sticky_ovf` was 1.
  - Response: `sticky_unf` = 1 and `sticky_ovf` = 0.
- Infinity is not invalid:
  - Stimulus: commit 32'h7F80_0000.
  - Response: `sticky_inv` stays 0.
- Reset mid-operation:
  - Stimulus: two entries buffered with `rf_busy` = 1, then `rst_n` pulsed low between clock edges.
  - Response: `pending` = 0, `in_ready` = 1 and `rf_we` = 0 immediately; no write occurs after `rf_busy` drops.
